// File: rtl/load_store_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit_if                                                       |
// | Request/response handshake and byte-wide memory port of the LSU.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface load_store_unit_if #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [1:0]                req_size;
  logic                      req_unsigned;
  logic [ADDR_BUS_WIDTH-1:0] req_addr;
  logic [DATA_BUS_WIDTH-1:0] req_wdata;
  logic                      resp_valid;
  logic [DATA_BUS_WIDTH-1:0] resp_rdata;
  logic                      resp_err;
  logic [ADDR_BUS_WIDTH-1:0] mem_addr;
  logic [7:0]                mem_wdata;
  logic                      mem_write_en;
  logic [7:0]                mem_rdata;

  // Core/memory environment side
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write_en
  );

  // Load/store unit side
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write_en
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_store_unit                                                          |
// | Serialises load/store requests into big-endian byte memory accesses.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_store_unit #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                    state_q;
  logic [1:0]                cnt_q;
  logic [1:0]                last_q;
  logic                      write_q;
  logic [1:0]                size_q;
  logic                      unsigned_q;
  logic [ADDR_BUS_WIDTH-1:0] addr_q;
  logic [DATA_BUS_WIDTH-1:0] wdata_q;
  logic [DATA_BUS_WIDTH-1:0] acc_q;
  logic                      resp_valid_q;
  logic                      resp_err_q;
  logic [DATA_BUS_WIDTH-1:0] resp_rdata_q;
  logic [ADDR_BUS_WIDTH-1:0] mem_addr_q;
  logic [7:0]                mem_wdata_q;
  logic                      mem_we_q;

  logic [1:0]                req_last_d;
  logic                      req_illegal_d;
  logic [1:0]                cnt_d;
  logic [DATA_BUS_WIDTH-1:0] acc_d;

  function automatic logic [7:0] byte_of(input logic [DATA_BUS_WIDTH-1:0] w,
                                         input logic [1:0] idx);
    byte_of = w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [DATA_BUS_WIDTH-1:0] extend(input logic [DATA_BUS_WIDTH-1:0] a,
                                                       input logic [1:0] sz,
                                                       input logic uns);
    case (sz)
      2'b00:   extend = {{24{~uns & a[7]}}, a[7:0]};
      2'b01:   extend = {{16{~uns & a[15]}}, a[15:0]};
      default: extend = a;
    endcase
  endfunction

  always_comb begin
    req_last_d = 2'd0;
    case (bus.req_size)
      2'b00:   req_last_d = 2'd0;
      2'b01:   req_last_d = 2'd1;
      default: req_last_d = 2'd3;
    endcase
    req_illegal_d = (bus.req_size == 2'b11) ||
                    ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    cnt_d = cnt_q + 2'd1;
    acc_d = {acc_q[DATA_BUS_WIDTH-9:0], bus.mem_rdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      unsigned_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      acc_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            write_q    <= bus.req_write;
            size_q     <= bus.req_size;
            unsigned_q <= bus.req_unsigned;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
            last_q     <= req_last_d;
            cnt_q      <= '0;
            acc_q      <= '0;
            if (req_illegal_d) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              // First byte is presented in the cycle right after the accept edge
              state_q     <= ACCESS;
              mem_addr_q  <= bus.req_addr;
              mem_we_q    <= bus.req_write;
              mem_wdata_q <= bus.req_write ? byte_of(bus.req_wdata, req_last_d) : 8'h00;
            end
          end
        end
        ACCESS: begin
          if (!write_q) acc_q <= acc_d;
          if (cnt_q == last_q) begin
            state_q      <= DONE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= write_q ? '0 : extend(acc_d, size_q, unsigned_q);
          end else begin
            cnt_q       <= cnt_d;
            mem_addr_q  <= addr_q + ADDR_BUS_WIDTH'(cnt_d);
            mem_wdata_q <= write_q ? byte_of(wdata_q, last_q - cnt_d) : 8'h00;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state_q == IDLE) && !reset;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_write_en = mem_we_q;

endmodule
`default_nettype wire
